// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the ALU op sequencer: ALUOp codes, request opcodes,
// FSM states and the decoded-control bundle.
package cpu_alu_pkg;

  localparam int DW_DEFAULT   = 16;
  localparam int IMMW_DEFAULT = 8;

  // ALUOp encodings understood by the external ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_BEQ = 3'b100;
  localparam logic [2:0] ALU_BLE = 3'b101;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_ADDI = 3'd4,
    OP_BEQ  = 3'd5,
    OP_BLE  = 3'd6,
    OP_ILL  = 3'd7
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       b_imm;      // operand B is the sign-extended immediate
    logic       wb_en;
    logic       is_branch;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and result signal bundle for the ALU op sequencer.
// slave = sequencer view, master = surrounding pipeline/ALU view.
interface alu_op_sequencer_if #(
  parameter int DW   = 16,
  parameter int IMMW = 8
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [DW-1:0]   req_rs;
  logic [DW-1:0]   req_rt;
  logic [IMMW-1:0] req_imm;
  logic [DW-1:0]   req_pc;

  logic [2:0]      alu_op;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [DW-1:0]   alu_result;
  logic            alu_zero;

  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   res_data;
  logic            res_wb_en;
  logic            res_br_taken;
  logic [DW-1:0]   res_br_tgt;
  logic            res_illegal;

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_imm, req_pc,
    input  alu_result, alu_zero, res_ready,
    output req_ready, alu_op, alu_a, alu_b,
    output res_valid, res_data, res_wb_en, res_br_taken, res_br_tgt, res_illegal
  );

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_imm, req_pc,
    output alu_result, alu_zero, res_ready,
    input  req_ready, alu_op, alu_a, alu_b,
    input  res_valid, res_data, res_wb_en, res_br_taken, res_br_tgt, res_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational request-opcode decoder: ALUOp, operand-B select, writeback,
// branch and illegal flags.
module alu_op_decode
  import cpu_alu_pkg::*;
(
  input  req_op_e op,
  output dec_t    dec
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    dec = '{alu_op: ALU_ADD, b_imm: 1'b0, wb_en: 1'b0, is_branch: 1'b0, illegal: 1'b0};
    case (op)
      OP_ADD:  begin dec.alu_op = ALU_ADD; dec.wb_en = 1'b1; end
      OP_SUB:  begin dec.alu_op = ALU_SUB; dec.wb_en = 1'b1; end
      OP_AND:  begin dec.alu_op = ALU_AND; dec.wb_en = 1'b1; end
      OP_OR:   begin dec.alu_op = ALU_OR;  dec.wb_en = 1'b1; end
      OP_ADDI: begin dec.alu_op = ALU_ADD; dec.wb_en = 1'b1; dec.b_imm = 1'b1; end
      OP_BEQ:  begin dec.alu_op = ALU_BEQ; dec.is_branch = 1'b1; end
      OP_BLE:  begin dec.alu_op = ALU_BLE; dec.is_branch = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator side of the external ALU: registers a decoded request, issues it
// for one cycle, and holds the result until consumed. ALU_SEQ_STATS_EN adds counters.
module alu_op_sequencer
  import cpu_alu_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int IMMW = IMMW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_taken
`endif
);

  state_e          state_q, state_d;
  logic            req_ready_q;
  req_op_e         op_q;
  logic [DW-1:0]   rs_q, rt_q, pc_q;
  logic [IMMW-1:0] imm_q;

  logic [DW-1:0]   res_data_q, res_br_tgt_q;
  logic            res_wb_en_q, res_br_taken_q, res_illegal_q;

  logic [2:0]      alu_op_d;
  logic [DW-1:0]   alu_a_d, alu_b_d;

  dec_t            dec;
  logic [DW-1:0]   imm_sext;
  logic            accept, drain;

  alu_op_decode u_decode (
    .op  (op_q),
    .dec (dec)
  );

  assign imm_sext = {{(DW-IMMW){imm_q[IMMW-1]}}, imm_q};
  assign accept   = bus.req_valid && req_ready_q;
  assign drain    = (state_q == ST_DONE) && bus.res_ready;

  // Next state plus ALU issue; the ALU sees only registered values, and zeros outside EXEC
  always_comb begin
    state_d  = state_q;
    alu_op_d = ALU_ADD;
    alu_a_d  = '0;
    alu_b_d  = '0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_DONE;
        if (!dec.illegal) begin
          alu_op_d = dec.alu_op;
          alu_a_d  = rs_q;
          alu_b_d  = dec.b_imm ? imm_sext : rt_q;
        end
      end
      ST_DONE: if (bus.res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all registers are reset so an aborted op leaves nothing visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b0;
      op_q           <= OP_ADD;
      rs_q           <= '0;
      rt_q           <= '0;
      imm_q          <= '0;
      pc_q           <= '0;
      res_data_q     <= '0;
      res_br_tgt_q   <= '0;
      res_wb_en_q    <= 1'b0;
      res_br_taken_q <= 1'b0;
      res_illegal_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      if (accept) begin
        op_q  <= req_op_e'(bus.req_op);
        rs_q  <= bus.req_rs;
        rt_q  <= bus.req_rt;
        imm_q <= bus.req_imm;
        pc_q  <= bus.req_pc;
      end
      if (state_q == ST_EXEC) begin
        res_data_q     <= dec.illegal ? '0 : bus.alu_result;
        res_wb_en_q    <= dec.wb_en;
        res_br_taken_q <= bus.alu_zero && dec.is_branch;
        res_br_tgt_q   <= pc_q + imm_sext;
        res_illegal_q  <= dec.illegal;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Saturating counts of consumed results and of consumed taken branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_taken <= '0;
    end else if (drain) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (res_br_taken_q && stat_taken != 16'hFFFF) stat_taken <= stat_taken + 16'd1;
    end
  end
`else
  logic unused_drain;
  assign unused_drain = drain;
`endif

  assign bus.req_ready    = req_ready_q;
  assign bus.alu_op       = alu_op_d;
  assign bus.alu_a        = alu_a_d;
  assign bus.alu_b        = alu_b_d;
  assign bus.res_valid    = (state_q == ST_DONE);
  assign bus.res_data     = res_data_q;
  assign bus.res_wb_en    = res_wb_en_q;
  assign bus.res_br_taken = res_br_taken_q;
  assign bus.res_br_tgt   = res_br_tgt_q;
  assign bus.res_illegal  = res_illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and hand-computed
// expectations; stats counters checked when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_ops = 0;
  int   exp_taken = 0;

  alu_op_sequencer_if #(.DW(16), .IMMW(8)) bus ();

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_taken;
  alu_op_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                        .stat_ops(stat_ops), .stat_taken(stat_taken));
`else
  alu_op_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    bus.alu_result = 16'h0000;
    case (bus.alu_op)
      3'b000: bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001: bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b100: bus.alu_result = {15'd0, bus.alu_a == bus.alu_b};
      3'b101: bus.alu_result = {15'd0, bus.alu_a <= bus.alu_b};
      default: bus.alu_result = 16'h0000;
    endcase
    bus.alu_zero = (bus.alu_result != 16'h0000);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [15:0] rs, rt,
                           input logic [7:0] imm, input logic [15:0] pc);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs    = rs;
    bus.req_rt    = rt;
    bus.req_imm   = imm;
    bus.req_pc    = pc;
  endtask

  // Issue one request, check EXEC issue, DONE result (optionally stalled), return to IDLE
  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] rs, rt,
                        input logic [7:0] imm, input logic [15:0] pc,
                        input logic [2:0] e_op, input logic [15:0] e_a, e_b, e_data,
                        input logic e_wb, e_br, input logic [15:0] e_tgt, input logic e_ill,
                        input int hold);
    int waited = 0;
    @(negedge clk);
    drive_req(op, rs, rt, imm, pc);
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      check({name, "_req_ready_timeout"}, 16'd0, 16'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);  // EXEC
    bus.req_valid = 1'b0;
    check({name, "_exec_req_ready"}, 16'(bus.req_ready), 16'd0);
    check({name, "_exec_res_valid"}, 16'(bus.res_valid), 16'd0);
    check({name, "_alu_op"}, 16'(bus.alu_op), 16'(e_op));
    check({name, "_alu_a"}, bus.alu_a, e_a);
    check({name, "_alu_b"}, bus.alu_b, e_b);
    @(negedge clk);  // DONE, two cycles after the handshake
    check({name, "_res_valid"}, 16'(bus.res_valid), 16'd1);
    check({name, "_res_data"}, bus.res_data, e_data);
    check({name, "_wb_en"}, 16'(bus.res_wb_en), 16'(e_wb));
    check({name, "_br_taken"}, 16'(bus.res_br_taken), 16'(e_br));
    check({name, "_illegal"}, 16'(bus.res_illegal), 16'(e_ill));
    if (op == 3'd5 || op == 3'd6) check({name, "_br_tgt"}, bus.res_br_tgt, e_tgt);
    if (hold > 0) begin
      bus.res_ready = 1'b0;
      drive_req(3'd0, 16'h1111, 16'h2222, 8'h00, 16'h0000);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, "_hold_valid"}, 16'(bus.res_valid), 16'd1);
        check({name, "_hold_data"}, bus.res_data, e_data);
        check({name, "_hold_wb_en"}, 16'(bus.res_wb_en), 16'(e_wb));
        check({name, "_hold_req_ready"}, 16'(bus.req_ready), 16'd0);
      end
      bus.req_valid = 1'b0;
      bus.res_ready = 1'b1;
    end
    @(negedge clk);  // back in IDLE
    check({name, "_idle_res_valid"}, 16'(bus.res_valid), 16'd0);
    check({name, "_idle_req_ready"}, 16'(bus.req_ready), 16'd1);
    check({name, "_idle_alu_a"}, bus.alu_a, 16'h0000);
    exp_ops++;
    if (e_br) exp_taken++;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_rs    = 16'h0000;
    bus.req_rt    = 16'h0000;
    bus.req_imm   = 8'h00;
    bus.req_pc    = 16'h0000;
    bus.res_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 16'(bus.req_ready), 16'd0);
    check("rst_res_valid", 16'(bus.res_valid), 16'd0);
    check("rst_res_data", bus.res_data, 16'h0000);
    check("rst_alu_op", 16'(bus.alu_op), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 16'(bus.req_ready), 16'd1);

    // Reset pulsed during EXEC aborts the op
    drive_req(3'd0, 16'h0003, 16'h0004, 8'h00, 16'h0000);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_in_exec_alu_a", bus.alu_a, 16'h0003);
    rst_n = 1'b0;
    #1;
    check("abort_res_valid", 16'(bus.res_valid), 16'd0);
    check("abort_alu_a", bus.alu_a, 16'h0000);
    check("abort_alu_b", bus.alu_b, 16'h0000);
    check("abort_req_ready", 16'(bus.req_ready), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_res_valid", 16'(bus.res_valid), 16'd0);
      check("abort_res_data", bus.res_data, 16'h0000);
    end
    check("abort_req_ready_after", 16'(bus.req_ready), 16'd1);

    //      name    op    rs        rt        imm    pc        aluop a         b         data      wb    br    tgt       ill   hold
    run_op("add",  3'd0, 16'h0003, 16'h0004, 8'h00, 16'h0000, 3'd0, 16'h0003, 16'h0004, 16'h0007, 1'b1, 1'b0, 16'h0000, 1'b0, 0);
    run_op("addi", 3'd4, 16'h0010, 16'h9999, 8'hFF, 16'h0200, 3'd0, 16'h0010, 16'hFFFF, 16'h000F, 1'b1, 1'b0, 16'h01FF, 1'b0, 0);
    run_op("sub",  3'd1, 16'h0000, 16'h0001, 8'h00, 16'h0000, 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 0);
    run_op("and",  3'd2, 16'hF0F0, 16'h3C3C, 8'h00, 16'h0000, 3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, 1'b0, 16'h0000, 1'b0, 0);
    run_op("or",   3'd3, 16'hF000, 16'h000F, 8'h00, 16'h0000, 3'd3, 16'hF000, 16'h000F, 16'hF00F, 1'b1, 1'b0, 16'h0000, 1'b0, 5);
    run_op("beq",  3'd5, 16'h1234, 16'h1234, 8'h04, 16'h0100, 3'd4, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b1, 16'h0104, 1'b0, 0);
    run_op("ble_nt", 3'd6, 16'h0005, 16'h0003, 8'hFC, 16'h0010, 3'd5, 16'h0005, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h000C, 1'b0, 0);
    run_op("ble_wrap", 3'd6, 16'h0003, 16'h0005, 8'h01, 16'hFFFF, 3'd5, 16'h0003, 16'h0005, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0, 0);
    run_op("ill",  3'd7, 16'h5555, 16'hAAAA, 8'h02, 16'h0300, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
    run_op("beq_nt", 3'd5, 16'h0001, 16'h0002, 8'h10, 16'h0020, 3'd4, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0030, 1'b0, 2);

`ifdef ALU_SEQ_STATS_EN
    check("stat_ops", stat_ops, 16'(exp_ops));
    check("stat_taken", stat_taken, 16'(exp_taken));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
